spart_rx: RTL and testbench

SPART_RX -- requirements
Module: spart_rx

---
 rtl/spart_rx.sv | 145 ++++++++++++++
 tb/tb_spart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// 8N1 serial receiver driven by an oversampled baud enable. It holds one received
// byte with its data-available, framing-error and overrun flags.
module spart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_baud_en,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    // The start bit is sampled on the tick that brings the count to OVERSAMPLE/2-1.
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rda_q, rda_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rxd_s;
    logic          byte_done;

    assign sync_d = {sync_q[0], rxd};
    assign rxd_s  = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // armed_q drops after a low stop sample so a held break yields a single frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        if (rx_baud_en) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s && armed_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else if (rxd_s) begin
                        armed_d = 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d     = '0;
                        shift_d   = {rxd_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        armed_d = rxd_s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_done = rx_baud_en && (state_q == STOP) && (cnt_q == BIT_LAST);

    // A completing byte takes priority over a coincident read.
    always_comb begin
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        if (byte_done) begin
            if (!rda_q || rd_en) begin
                rx_data_d = shift_q;
                rda_d     = 1'b1;
                ferr_d    = !rxd_s;
                ovr_d     = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_en) begin
            rda_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: 8N1 frames at 16 ticks/bit with a tick every 4 clocks,
// a table of directed frames, hand sequences for corner cases and random frames.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       rx_baud_en;
    logic [7:0] rx_data;
    logic       rda, framing_err, overrun;
    logic [1:0] div = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_data;
    logic       m_rda, m_fe, m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       rd_before;
        logic       rd_co;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_fe;
        logic       e_ovr;
    } vec_t;

    vec_t vt[8];

    spart_rx #(.OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_baud_en  (rx_baud_en),
        .rxd         (rxd),
        .rd_en       (rd_en),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign rx_baud_en = (div == 2'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic r,
                             input logic f, input logic o);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
        check({tag, "_rda"}, {31'd0, rda}, {31'd0, r});
        check({tag, "_ferr"}, {31'd0, framing_err}, {31'd0, f});
        check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, o});
        $display("[TB] %s: rx_data=%02h rda=%0b ferr=%0b ovr=%0b", tag, rx_data, rda,
                 framing_err, overrun);
    endtask

    task automatic m_read();
        m_rda = 1'b0;
        m_fe  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic m_frame(input logic [7:0] d, input logic stop, input logic co);
        if (!m_rda || co) begin
            m_data = d;
            m_rda  = 1'b1;
            m_fe   = !stop;
            m_ovr  = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge of a tick cycle.
    task automatic wait_tick();
        while (!rx_baud_en) @(negedge clk);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // One 640-clock frame; cycle 608 is the cycle whose tick samples the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at,
                              input bit chk_lat);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        wait_tick();
        for (int c = 0; c < 640; c++) begin
            rxd   = bits[c / 64];
            rd_en = (c == rd_at);
            if (chk_lat && c == 608) check("latency_before", {31'd0, rda}, 32'd0);
            if (chk_lat && c == 609) check("latency_after", {31'd0, rda}, 32'd1);
            @(negedge clk);
        end
        rxd   = 1'b1;
        rd_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b1, 8,  1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'h11, 1'b1, 16, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h22, 1'b1, 0,  1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        vt[4] = '{8'h11, 1'b1, 8,  1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h77, 1'b1, 0,  1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h99, 1'b0, 4,  1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1};
        vt[7] = '{8'h00, 1'b1, 16, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rxd = 1'b1;
            repeat (vt[i].gap) @(negedge clk);
            if (vt[i].rd_before) begin
                read_pulse();
                check_all($sformatf("vec%0d_read", i), vt[(i > 0) ? i - 1 : 0].e_data,
                          1'b0, 1'b0, 1'b0);
            end
            send_frame(vt[i].data, vt[i].stop, vt[i].rd_co ? 608 : -1, (i == 0));
            check_all($sformatf("vec%0d", i), vt[i].e_data, vt[i].e_rda, vt[i].e_fe,
                      vt[i].e_ovr);
        end

        // Short lows: 5 and 7 ticks are rejected, 8 ticks starts an all-ones frame.
        repeat (16) @(negedge clk);
        read_pulse();
        wait_tick();
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (700) @(negedge clk);
        check_all("glitch5", 8'h00, 1'b0, 1'b0, 1'b0);
        wait_tick();
        rxd = 1'b0;
        repeat (28) @(negedge clk);
        rxd = 1'b1;
        repeat (700) @(negedge clk);
        check_all("glitch7", 8'h00, 1'b0, 1'b0, 1'b0);
        wait_tick();
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        repeat (700) @(negedge clk);
        check_all("low8", 8'hFF, 1'b1, 1'b0, 1'b0);
        read_pulse();
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        check_all("after_glitch", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Break: one zero byte with framing error, no re-arm while the line stays low.
        read_pulse();
        wait_tick();
        rxd = 1'b0;
        repeat (1500) @(negedge clk);
        check_all("break", 8'h00, 1'b1, 1'b1, 1'b0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        read_pulse();
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        check_all("after_break", 8'hA5, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of data bit 3 of 0xF0.
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hF0, 1'b0};
            wait_tick();
            for (int c = 0; c < 289; c++) begin
                rxd = bits[c / 64];
                if (c == 288) begin
                    rst_n = 1'b0;
                    #1;
                    check_all("reset_midframe", 8'h00, 1'b0, 1'b0, 1'b0);
                end else begin
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        check_all("after_reset", 8'h81, 1'b1, 1'b0, 1'b0);

        m_data = 8'h81;
        m_rda  = 1'b1;
        m_fe   = 1'b0;
        m_ovr  = 1'b0;
        begin
            logic last_stop;
            last_stop = 1'b1;
            for (int i = 0; i < 30; i++) begin
                logic [7:0] d;
                logic       stop, rdb, co;
                int         gap;
                d    = 8'($urandom_range(0, 255));
                stop = ($urandom_range(0, 4) != 0);
                rdb  = ($urandom_range(0, 2) == 0);
                co   = ($urandom_range(0, 3) == 0);
                gap  = $urandom_range(0, 10);
                if (!last_stop || rdb) gap = gap + 16;
                repeat (gap) @(negedge clk);
                if (rdb) begin
                    read_pulse();
                    m_read();
                end
                send_frame(d, stop, co ? 608 : -1, 1'b0);
                m_frame(d, stop, co);
                check_all($sformatf("rand%0d", i), m_data, m_rda, m_fe, m_ovr);
                last_stop = stop;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
